// File: rtl/axis_bf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_bf_pkg                                                                |
// | Shared types, width helpers and round/saturate for axis_beam_weighter.     |
// | Optional feature macro: AXIS_BF_SAT_EN (rounded, saturated output lanes).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package axis_bf_pkg;

   typedef logic [0:0] state_t;
   localparam state_t S_IDLE = 1'b0;
   localparam state_t S_PKT  = 1'b1;

`ifdef AXIS_BF_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   function automatic int msample_w(input int sample_w, input int weight_w, input int out_w);
      return SAT_EN ? out_w : sample_w + weight_w;
   endfunction

   function automatic int mdata_w(input int num_samples, input int sample_out_w);
      return num_samples * sample_out_w;
   endfunction

   // Round half up by adding half an LSB of the shifted result, then clamp.
   function automatic logic signed [31:0] round_sat(input logic signed [31:0] p,
                                                    input int shift,
                                                    input int out_w);
      logic signed [31:0] r;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      r  = (p + ((32'sd1 <<< shift) >>> 1)) >>> shift;
      hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (out_w - 1));
      if (r > hi) begin
         r = hi;
      end else if (r < lo) begin
         r = lo;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_bf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_bf_if                                                                 |
// | Stream, weight-load and status signals of axis_beam_weighter.              |
// | Optional feature macro: AXIS_BF_SAT_EN (changes output lane width).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface axis_bf_if
   import axis_bf_pkg::*;
#(
   parameter int NUM_SAMPLES = 16,
   parameter int SAMPLE_W    = 8,
   parameter int WEIGHT_W    = 8,
   parameter int OUT_W       = 16,
   parameter int CNT_W       = 16
);
   localparam int MSAMPLE_W = msample_w(SAMPLE_W, WEIGHT_W, OUT_W);
   localparam int MDATA_W   = mdata_w(NUM_SAMPLES, MSAMPLE_W);
   localparam int LANE_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

   logic                            s_axis_tvalid;
   logic                            s_axis_tready;
   logic [NUM_SAMPLES*SAMPLE_W-1:0] s_axis_tdata;
   logic                            s_axis_tlast;
   logic                            w_wr_en;
   logic [LANE_W-1:0]               w_wr_lane;
   logic [WEIGHT_W-1:0]             w_wr_data;
   logic                            w_commit;
   logic                            w_pending;
   logic                            m_axis_tvalid;
   logic                            m_axis_tready;
   logic [MDATA_W-1:0]              m_axis_tdata;
   logic [MDATA_W/8-1:0]            m_axis_tkeep;
   logic                            m_axis_tlast;
   logic [CNT_W-1:0]                pkt_cnt;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
      input  w_wr_en, w_wr_lane, w_wr_data, w_commit,
      input  m_axis_tready,
      output s_axis_tready, w_pending,
      output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, pkt_cnt
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
      output w_wr_en, w_wr_lane, w_wr_data, w_commit,
      output m_axis_tready,
      input  s_axis_tready, w_pending,
      input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, pkt_cnt
   );

endinterface
`default_nettype wire

// File: rtl/axis_bf_lane_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_bf_lane_mult                                                          |
// | One signed sample x weight lane with its output register (stage 2).        |
// | Optional feature macro: AXIS_BF_SAT_EN (round and saturate the product).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axis_bf_lane_mult
   import axis_bf_pkg::*;
#(
   parameter int SAMPLE_W  = 8,
   parameter int WEIGHT_W  = 8,
   parameter int MSAMPLE_W = SAMPLE_W + WEIGHT_W
`ifdef AXIS_BF_SAT_EN
   ,
   parameter int SHIFT     = 7
`endif
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       in_valid,
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic signed [WEIGHT_W-1:0] weight,
   output logic [MSAMPLE_W-1:0]       out_data
);
   localparam int P_W = SAMPLE_W + WEIGHT_W;

   logic signed [P_W-1:0]   prod;
   logic [MSAMPLE_W-1:0]    lane_res;
   logic [MSAMPLE_W-1:0]    data_d;
   logic [MSAMPLE_W-1:0]    data_q;

   assign prod = sample * weight;

`ifdef AXIS_BF_SAT_EN
   logic signed [31:0] rs;
   assign rs       = round_sat(32'(prod), SHIFT, MSAMPLE_W);
   assign lane_res = rs[MSAMPLE_W-1:0];
`else
   assign lane_res = prod;
`endif

   // Bubbles load zero so the output bus reads 0 whenever it is not valid.
   always_comb begin
      data_d = data_q;
      if (en) begin
         data_d = in_valid ? lane_res : '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign out_data = data_q;

endmodule
`default_nettype wire

// File: rtl/axis_beam_weighter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_beam_weighter                                                         |
// | AXI-stream per-lane weighter, double-buffered weights swapped at packet    |
// | boundaries, 2-stage pipeline. Optional macro: AXIS_BF_SAT_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axis_beam_weighter
   import axis_bf_pkg::*;
#(
   parameter int NUM_SAMPLES = 16,
   parameter int SAMPLE_W    = 8,
   parameter int WEIGHT_W    = 8,
   parameter int OUT_W       = 16,
   parameter int SHIFT       = 7,
   parameter int CNT_W       = 16
) (
   input  logic     CLK,
   input  logic     reset,
   axis_bf_if.slave bus
);
   localparam int MSAMPLE_W = msample_w(SAMPLE_W, WEIGHT_W, OUT_W);
   localparam int MDATA_W   = mdata_w(NUM_SAMPLES, MSAMPLE_W);
   localparam int KEEP_W    = MDATA_W / 8;
   localparam int DATA_W    = NUM_SAMPLES * SAMPLE_W;

   if (SHIFT < 0 || SHIFT > 30) begin : g_bad_shift
      $error("axis_beam_weighter: SHIFT out of range");
   end

   logic                       en;
   logic                       accept;
   logic                       swap;
   state_t                     state_d, state_q;
   logic                       pending_d, pending_q;
   logic signed [WEIGHT_W-1:0] shadow_d [NUM_SAMPLES];
   logic signed [WEIGHT_W-1:0] shadow_q [NUM_SAMPLES];
   logic signed [WEIGHT_W-1:0] active_d [NUM_SAMPLES];
   logic signed [WEIGHT_W-1:0] active_q [NUM_SAMPLES];
   logic                       s1_valid_d, s1_valid_q;
   logic                       s1_last_d, s1_last_q;
   logic [DATA_W-1:0]          s1_data_d, s1_data_q;
   logic signed [WEIGHT_W-1:0] s1_w_d [NUM_SAMPLES];
   logic signed [WEIGHT_W-1:0] s1_w_q [NUM_SAMPLES];
   logic                       m_valid_d, m_valid_q;
   logic                       m_last_d, m_last_q;
   logic [CNT_W-1:0]           pkt_cnt_d, pkt_cnt_q;
   logic [MDATA_W-1:0]         m_data;

   assign en     = ~m_valid_q | bus.m_axis_tready;
   assign accept = bus.s_axis_tvalid & en & ~reset;
   // Swap points: idle with nothing accepted, or the accept of a packet's last beat.
   assign swap   = pending_q & (((state_q == S_IDLE) & ~accept) | (accept & bus.s_axis_tlast));

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = bus.s_axis_tlast ? S_IDLE : S_PKT;
      end
      pending_d = swap ? 1'b0 : (pending_q | bus.w_commit);
      active_d  = swap ? shadow_q : active_q;
      shadow_d  = shadow_q;
      if (bus.w_wr_en) begin
         shadow_d[bus.w_wr_lane] = bus.w_wr_data;
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      s1_data_d  = s1_data_q;
      s1_w_d     = s1_w_q;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      if (en) begin
         s1_valid_d = bus.s_axis_tvalid;
         s1_last_d  = bus.s_axis_tlast;
         s1_data_d  = bus.s_axis_tdata;
         s1_w_d     = active_q;
         m_valid_d  = s1_valid_q;
         m_last_d   = s1_valid_q & s1_last_q;
      end
      pkt_cnt_d = pkt_cnt_q + CNT_W'(m_valid_q & bus.m_axis_tready & m_last_q);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pending_q  <= 1'b0;
         shadow_q   <= '{default: '0};
         active_q   <= '{default: '0};
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         s1_w_q     <= '{default: '0};
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         s1_data_q  <= s1_data_d;
         s1_w_q     <= s1_w_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   for (genvar i = 0; i < NUM_SAMPLES; i++) begin : g_lane
      axis_bf_lane_mult #(
         .SAMPLE_W  (SAMPLE_W),
         .WEIGHT_W  (WEIGHT_W),
         .MSAMPLE_W (MSAMPLE_W)
`ifdef AXIS_BF_SAT_EN
         ,
         .SHIFT     (SHIFT)
`endif
      ) u_lane (
         .CLK      (CLK),
         .reset    (reset),
         .en       (en),
         .in_valid (s1_valid_q),
         .sample   (s1_data_q[i*SAMPLE_W +: SAMPLE_W]),
         .weight   (s1_w_q[i]),
         .out_data (m_data[i*MSAMPLE_W +: MSAMPLE_W])
      );
   end

   assign bus.s_axis_tready = en & ~reset;
   assign bus.w_pending     = pending_q;
   assign bus.m_axis_tvalid = m_valid_q;
   assign bus.m_axis_tdata  = m_data;
   assign bus.m_axis_tkeep  = {KEEP_W{m_valid_q}};
   assign bus.m_axis_tlast  = m_last_q;
   assign bus.pkt_cnt       = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_beam_weighter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axis_beam_weighter                                                      |
// | Scoreboard bench for axis_beam_weighter against a behavioural model.       |
// | Optional macro: AXIS_BF_SAT_EN (OUT_W=8, SHIFT=0 in this bench).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axis_beam_weighter;
   localparam int NS    = 16;
   localparam int SW    = 8;
   localparam int WW    = 8;
   localparam int CNT_W = 16;
`ifdef AXIS_BF_SAT_EN
   localparam int OUT_W = 8;
   localparam int SHIFT = 0;
   localparam int MSW   = OUT_W;
   localparam logic [MSW-1:0] T1_LANE = 8'h7F;
`else
   localparam int OUT_W = 16;
   localparam int SHIFT = 7;
   localparam int MSW   = SW + WW;
   localparam logic [MSW-1:0] T1_LANE = 16'h0080;
`endif
   localparam int MDW  = NS * MSW;
   localparam int KW   = MDW / 8;
   localparam int DW   = NS * SW;
   localparam int LW   = $clog2(NS);
   localparam int HALF = (1 << SHIFT) / 2;

   typedef struct packed {
      logic [MDW-1:0] data;
      logic           last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axis_bf_if #(.NUM_SAMPLES(NS), .SAMPLE_W(SW), .WEIGHT_W(WW), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

   axis_beam_weighter #(
      .NUM_SAMPLES (NS),
      .SAMPLE_W    (SW),
      .WEIGHT_W    (WW),
      .OUT_W       (OUT_W),
      .SHIFT       (SHIFT),
      .CNT_W       (CNT_W)
   ) dut (
      .CLK   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int   checks = 0;
   int   passes = 0;
   int   pkts_sent = 0;
   int   beats = 0;
   int   m_active [NS];
   int   m_shadow [NS];
   bit   m_pend;
   bit   m_inpkt;
   exp_t exp_q [$];
   logic last_acc;

   task automatic chk(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   function automatic int lane_out(input int p);
      int r;
      r = p;
`ifdef AXIS_BF_SAT_EN
      r = (p + HALF) >>> SHIFT;
      if (r > (1 << (OUT_W - 1)) - 1) r = (1 << (OUT_W - 1)) - 1;
      if (r < -(1 << (OUT_W - 1)))    r = -(1 << (OUT_W - 1));
`endif
      return r;
   endfunction

   function automatic logic [MDW-1:0] ref_beat(input logic [DW-1:0] d);
      logic [MDW-1:0] r;
      logic [SW-1:0]  s8;
      int             s;
      r = '0;
      for (int i = 0; i < NS; i++) begin
         s8 = d[i*SW +: SW];
         s  = int'($signed(s8));
         r[i*MSW +: MSW] = MSW'(lane_out(s * m_active[i]));
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_active[i] = 0;
         m_shadow[i] = 0;
      end
      m_pend    = 1'b0;
      m_inpkt   = 1'b0;
      pkts_sent = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic acc, input logic [DW-1:0] d, input logic l, input logic wen,
                             input logic [LW-1:0] lane, input logic [WW-1:0] wd, input logic cm);
      exp_t e;
      bit   sw;
      if (acc) begin
         e.data = ref_beat(d);
         e.last = l;
         exp_q.push_back(e);
         beats++;
         if (l) pkts_sent++;
      end
      sw = m_pend && ((acc && l) || (!m_inpkt && !acc));
      if (acc) m_inpkt = !l;
      if (sw) begin
         m_active = m_shadow;
         m_pend   = 1'b0;
      end else if (cm) begin
         m_pend = 1'b1;
      end
      if (wen) m_shadow[lane] = int'($signed(wd));
   endtask

   // mode: 0 = downstream stalled, 1 = downstream ready, 2 = random ready
   task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic wen,
                       input logic [LW-1:0] lane, input logic [WW-1:0] wd, input logic cm, input int mode);
      @(posedge clk);
      #1;
      if (!rst) chk("w_pending", MDW'(bus.w_pending), MDW'(m_pend));
      bus.s_axis_tvalid = v;
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = l;
      bus.w_wr_en       = wen;
      bus.w_wr_lane     = lane;
      bus.w_wr_data     = wd;
      bus.w_commit      = cm;
      bus.m_axis_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      #1;
      last_acc = v & bus.s_axis_tready;
      if (!rst) model_step(last_acc, d, l, wen, lane, wd, cm);
   endtask

   task automatic idle(input int mode);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, mode);
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic wen, input logic [LW-1:0] lane,
                            input logic [WW-1:0] wd, input logic cm, input int mode);
      int n;
      n = 0;
      do begin
         step(1'b1, d, l, wen, lane, wd, cm, mode);
         n++;
      end while (!last_acc && n < 200);
      if (!last_acc) begin
         checks++;
         $display("FAIL accept_timeout: beat not accepted after %0d cycles, required acceptance", n);
      end
   endtask

   task automatic load_weights(input int mode_sel);
      for (int i = 0; i < NS; i++) begin
         logic [WW-1:0] w;
         case (mode_sel)
            0:       w = 8'h40;
            1:       w = WW'(i - 8);
            default: w = WW'($urandom);
         endcase
         step(1'b0, '0, 1'b0, 1'b1, LW'(i), w, 1'b0, 1);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Scoreboard monitor: pops an expected beat on every output handshake.
   logic [MDW-1:0] held_data;
   logic           held_last;
   bit             held = 1'b0;
   always @(posedge clk) begin
      exp_t e;
      #3;
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid", MDW'(bus.m_axis_tvalid), MDW'(1'b1));
            chk("stall_data", bus.m_axis_tdata, held_data);
            chk("stall_last", MDW'(bus.m_axis_tlast), MDW'(held_last));
         end
         held = 1'b0;
         if (bus.m_axis_tvalid) begin
            chk("tkeep", MDW'(bus.m_axis_tkeep), MDW'({KW{1'b1}}));
            if (bus.m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_beat: got data %h, required no output", bus.m_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("tdata", bus.m_axis_tdata, e.data);
                  chk("tlast", MDW'(bus.m_axis_tlast), MDW'(e.last));
               end
            end else begin
               held      = 1'b1;
               held_data = bus.m_axis_tdata;
               held_last = bus.m_axis_tlast;
            end
         end else begin
            chk("idle_tdata", bus.m_axis_tdata, '0);
            chk("idle_tkeep", MDW'(bus.m_axis_tkeep), '0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      rst               = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = 1'b0;
      bus.w_wr_en       = 1'b0;
      bus.w_wr_lane     = '0;
      bus.w_wr_data     = '0;
      bus.w_commit      = 1'b0;
      bus.m_axis_tready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready", MDW'(bus.s_axis_tready), '0);
      chk("rst_tvalid", MDW'(bus.m_axis_tvalid), '0);
      chk("rst_tdata", bus.m_axis_tdata, '0);
      chk("rst_tkeep", MDW'(bus.m_axis_tkeep), '0);
      chk("rst_tlast", MDW'(bus.m_axis_tlast), '0);
      chk("rst_pending", MDW'(bus.w_pending), '0);
      chk("rst_pkt_cnt", MDW'(bus.pkt_cnt), '0);
      rst = 1'b0;

      // 1: weights 0x40 committed while idle, one beat of 0x02 lanes
      load_weights(0);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1);
      idle(1);
      send_beat({NS{8'h02}}, 1'b1, 1'b0, '0, '0, 1'b0, 1);
      idle(1);
      chk("lat_1cycle_valid", MDW'(bus.m_axis_tvalid), '0);
      @(posedge clk);
      #1;
      chk("lat_2cycle_valid", MDW'(bus.m_axis_tvalid), MDW'(1'b1));
      chk("t1_tdata", bus.m_axis_tdata, {NS{T1_LANE}});
      chk("t1_tkeep", MDW'(bus.m_axis_tkeep), MDW'({KW{1'b1}}));

      // 2: lane weights i-8 against full-scale negative samples
      load_weights(1);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1);
      idle(1);
      send_beat({NS{8'h80}}, 1'b1, 1'b0, '0, '0, 1'b0, 1);
      send_beat({NS{8'h7F}}, 1'b1, 1'b0, '0, '0, 1'b0, 1);
      repeat (3) idle(1);

      // 3: commit on beat 2 of a 4-beat packet; swap lands on the tlast accept
      load_weights(2);
      send_beat(rand_data(), 1'b0, 1'b0, '0, '0, 1'b0, 1);
      send_beat(rand_data(), 1'b0, 1'b0, '0, '0, 1'b1, 1);
      send_beat(rand_data(), 1'b0, 1'b0, '0, '0, 1'b0, 1);
      chk("t3_pending_mid", MDW'(m_pend), MDW'(1'b1));
      send_beat(rand_data(), 1'b1, 1'b0, '0, '0, 1'b0, 1);
      send_beat(rand_data(), 1'b0, 1'b0, '0, '0, 1'b0, 1);
      send_beat(rand_data(), 1'b1, 1'b0, '0, '0, 1'b0, 1);
      repeat (3) idle(1);

      // 4: random traffic, gaps, weight updates and 50% downstream ready
      beats = 0;
      while (beats < 1000) begin
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(0, 2)) idle(2);
            send_beat(rand_data(), 1'(b == len - 1), 1'($urandom_range(0, 7) == 0), LW'($urandom),
                      WW'($urandom), 1'($urandom_range(0, 15) == 0), 2);
         end
      end
      repeat (12) idle(1);
      chk("t4_drained", MDW'(exp_q.size()), '0);
      chk("t4_pkt_cnt", MDW'(bus.pkt_cnt), MDW'(CNT_W'(pkts_sent)));

      // 5: reset with both stages full and a swap pending
      load_weights(2);
      send_beat(rand_data(), 1'b0, 1'b0, '0, '0, 1'b0, 0);
      send_beat(rand_data(), 1'b0, 1'b0, '0, '0, 1'b0, 0);
      step(1'b1, rand_data(), 1'b0, 1'b0, '0, '0, 1'b1, 0);
      @(posedge clk);
      #1;
      rst               = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      bus.w_commit      = 1'b0;
      model_reset();
      #1;
      chk("t5_tready_in_rst", MDW'(bus.s_axis_tready), '0);
      @(posedge clk);
      #1;
      chk("t5_tvalid", MDW'(bus.m_axis_tvalid), '0);
      chk("t5_pkt_cnt", MDW'(bus.pkt_cnt), '0);
      chk("t5_pending", MDW'(bus.w_pending), '0);
      rst = 1'b0;
      send_beat({NS{8'h5A}}, 1'b0, 1'b0, '0, '0, 1'b0, 1);
      send_beat(rand_data(), 1'b1, 1'b0, '0, '0, 1'b0, 1);
      load_weights(2);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1);
      idle(1);
      send_beat(rand_data(), 1'b0, 1'b0, '0, '0, 1'b0, 1);
      send_beat(rand_data(), 1'b1, 1'b0, '0, '0, 1'b0, 1);
      repeat (5) idle(1);
      chk("t5_drained", MDW'(exp_q.size()), '0);
      chk("t5_pkt_cnt_after", MDW'(bus.pkt_cnt), MDW'(CNT_W'(pkts_sent)));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
